// File: rtl/inst_field_encoder.sv
// inst_field_encoder: packs RV32I instruction fields into 32-bit words and streams them to the imem loader.
// Rev 1.0 -- define UTYPE_ENCODE_EN to accept LUI/AUIPC (U-type) bundles.
`default_nettype none

module inst_field_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        in_opcode,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [2:0]        in_funct3,
  input  logic [6:0]        in_funct7,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_addr,
  output logic              err,
  output logic [1:0]        err_code,
  input  logic              err_clear,
  output logic [CNT_W-1:0]  enc_count
);

  localparam logic [6:0] OP_ARITH     = 7'b0110011;
  localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
  localparam logic [6:0] OP_LOAD      = 7'b0000011;
  localparam logic [6:0] OP_JALR      = 7'b1100111;
  localparam logic [6:0] OP_STORE     = 7'b0100011;
  localparam logic [6:0] OP_BRANCH    = 7'b1100011;
  localparam logic [6:0] OP_JAL       = 7'b1101111;
`ifdef UTYPE_ENCODE_EN
  localparam logic [6:0] OP_LUI       = 7'b0110111;
  localparam logic [6:0] OP_AUIPC     = 7'b0010111;
`endif

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OPCODE   = 2'b01;
  localparam logic [1:0] ERR_RANGE    = 2'b10;
  localparam logic [1:0] ERR_ALIGN    = 2'b11;

  typedef enum logic [0:0] {
    S_RUN = 1'b0,
    S_ERR = 1'b1
  } state_t;

  state_t state, state_next;

  logic [31:0] enc_inst;
  logic [1:0]  enc_code;
  logic        fits_i;
  logic        fits_b;
  logic        fits_j;
  logic        accept;
  logic        load;
  logic        bad;
  logic        handshake;

  // An immediate fits its field when every bit above the field's sign bit matches it.
  assign fits_i = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign fits_b = (&in_imm[31:12]) | ~(|in_imm[31:12]);
  assign fits_j = (&in_imm[31:20]) | ~(|in_imm[31:20]);

  always_comb begin
    enc_inst = '0;
    enc_code = ERR_NONE;
    case (in_opcode)
      OP_ARITH: begin
        enc_inst = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
      end
      OP_ARITH_IMM, OP_LOAD, OP_JALR: begin
        enc_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        if (!fits_i) enc_code = ERR_RANGE;
      end
      OP_STORE: begin
        enc_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        if (!fits_i) enc_code = ERR_RANGE;
      end
      OP_BRANCH: begin
        enc_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                    in_imm[4:1], in_imm[11], in_opcode};
        if (!fits_b)       enc_code = ERR_RANGE;
        else if (in_imm[0]) enc_code = ERR_ALIGN;
      end
      OP_JAL: begin
        enc_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        if (!fits_j)       enc_code = ERR_RANGE;
        else if (in_imm[0]) enc_code = ERR_ALIGN;
      end
`ifdef UTYPE_ENCODE_EN
      OP_LUI, OP_AUIPC: begin
        enc_inst = {in_imm[31:12], in_rd, in_opcode};
        if (|in_imm[11:0]) enc_code = ERR_RANGE;
      end
`endif
      default: begin
        enc_code = ERR_OPCODE;
      end
    endcase
  end

  assign in_ready  = (state == S_RUN) && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign load      = accept && (enc_code == ERR_NONE);
  assign bad       = accept && (enc_code != ERR_NONE);
  assign handshake = out_valid && out_ready;

  always_comb begin
    state_next = state;
    case (state)
      S_RUN:   if (bad)       state_next = S_ERR;
      S_ERR:   if (err_clear) state_next = S_RUN;
      default:                state_next = S_RUN;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (bad) begin
      err      <= 1'b1;
      err_code <= enc_code;
    end else if ((state == S_ERR) && err_clear) begin
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end
  end

  // The address tags the word sitting in the output register; it advances only when that word leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_inst  <= '0;
      out_addr  <= BASE_ADDR;
      enc_count <= '0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_inst  <= enc_inst;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
      if (handshake) begin
        out_addr  <= out_addr + ADDR_W'(4);
        enc_count <= enc_count + CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire
